ccw_busy_responder: RTL and testbench

CCW_BUSY_RESPONDER -- requirements
Module: ccw_busy_responder

---
 rtl/ccw_busy_responder.sv | 107 ++++++++++
 tb/tb_ccw_busy_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ccw_busy_responder.sv
// CCW busy responder: replies to each valid command control word after a fixed gap,
// reporting busy/ready, and counts consecutive busy replies within a repeat window.
`ifndef CLK_FREQ
`define CLK_FREQ 50_000_000
`endif

module ccw_busy_responder #(
   parameter int REPLY_GAP_TICKS = 4,
   parameter int WINDOW_TICKS    = ((`CLK_FREQ) / 8) - 1
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        ccw_valid,
   input  logic [15:0] ccw_word,
   input  logic        ccw_err,
   input  logic        dev_busy,
   output logic        reply_req,
   output logic        reply_busy,
   output logic        ccw_accepted,
   output logic [15:0] ccw_out,
   output logic [1:0]  busy_cnt,
   output logic        ccw_overrun
);

   localparam int GW = (REPLY_GAP_TICKS > 1) ? $clog2(REPLY_GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(REPLY_GAP_TICKS - 1);
   localparam logic [23:0]   WIN_LAST = 24'(WINDOW_TICKS);

   typedef enum logic [1:0] {IDLE, GAP, REPLY} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] gap_cnt;
   logic [23:0]   win_cnt;
   logic [15:0]   word_q;
   logic          decision_q;
   logic          take_ccw;

   assign take_ccw = (state_q == IDLE) && ccw_valid && !ccw_err;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      reply_req    = 1'b0;
      reply_busy   = 1'b0;
      ccw_accepted = 1'b0;
      case (state_q)
         IDLE:    if (take_ccw) state_d = GAP;
         GAP:     if (gap_cnt == GAP_LAST) state_d = REPLY;
         REPLY: begin
            reply_req    = 1'b1;
            reply_busy   = decision_q;
            ccw_accepted = !decision_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         gap_cnt     <= '0;
         win_cnt     <= '0;
         word_q      <= '0;
         decision_q  <= 1'b0;
         ccw_out     <= '0;
         busy_cnt    <= '0;
         ccw_overrun <= 1'b0;
      end else begin
         state_q <= state_d;

         // Word and busy decision are frozen at receipt; later dev_busy changes are ignored.
         if (take_ccw) begin
            word_q     <= ccw_word;
            decision_q <= dev_busy;
            gap_cnt    <= '0;
         end else if (state_q == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end

         if (ccw_valid && (state_q != IDLE))
            ccw_overrun <= 1'b1;

         if (ccw_accepted) begin
            ccw_out  <= word_q;
            busy_cnt <= 2'd0;
            win_cnt  <= '0;
         end else if (reply_busy) begin
            // A busy reply landing on window expiry starts a fresh window at count 1.
            win_cnt <= '0;
            if ((busy_cnt != 2'd0) && (win_cnt == WIN_LAST))
               busy_cnt <= 2'd1;
            else if (busy_cnt != 2'd3)
               busy_cnt <= busy_cnt + 2'd1;
         end else if (busy_cnt != 2'd0) begin
            if (win_cnt == WIN_LAST) begin
               busy_cnt <= 2'd0;
               win_cnt  <= '0;
            end else begin
               win_cnt <= win_cnt + 24'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ccw_busy_responder.sv
// Scoreboard bench for ccw_busy_responder: the driver predicts each reply from the
// receipt cycle, a negedge monitor compares DUT outputs against that prediction.
module tb_ccw_busy_responder;

   localparam int GAP = 4;
   localparam int WIN = 20;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        ccw_valid;
   logic [15:0] ccw_word;
   logic        ccw_err;
   logic        dev_busy;
   logic        reply_req;
   logic        reply_busy;
   logic        ccw_accepted;
   logic [15:0] ccw_out;
   logic [1:0]  busy_cnt;
   logic        ccw_overrun;

   ccw_busy_responder #(.REPLY_GAP_TICKS(GAP), .WINDOW_TICKS(WIN)) dut (
      .clk(clk), .n_rst(n_rst), .ccw_valid(ccw_valid), .ccw_word(ccw_word),
      .ccw_err(ccw_err), .dev_busy(dev_busy), .reply_req(reply_req),
      .reply_busy(reply_busy), .ccw_accepted(ccw_accepted), .ccw_out(ccw_out),
      .busy_cnt(busy_cnt), .ccw_overrun(ccw_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        busy;
      logic [15:0] word;
   } exp_t;

   exp_t        q[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          pend_end = -1;
   bit          ovr_set = 0;
   int          ovr_cyc = 0;
   int          m_cnt = 0;
   int          m_last = 0;
   logic [15:0] m_out = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Busy count is held for WIN+1 cycles after the last busy reply, then drops to 0.
   function automatic int exp_cnt(input int c);
      if (m_cnt == 0 || (c - m_last) > WIN + 1) return 0;
      return m_cnt;
   endfunction

   function automatic void issue(input logic e, input logic b, input logic [15:0] w);
      if (cyc <= pend_end) begin
         if (!ovr_set) begin
            ovr_set = 1;
            ovr_cyc = cyc;
         end
      end else if (!e) begin
         q.push_back('{cyc + GAP + 1, b, w});
         pend_end = cyc + GAP + 1;
      end
   endfunction

   task automatic drive(input logic v, input logic e, input logic b, input logic [15:0] w);
      @(posedge clk); #1;
      ccw_valid = v; ccw_err = e; dev_busy = b; ccw_word = w;
      if (v) issue(e, b, w);
   endtask

   task automatic send(input logic [15:0] w, input logic b);
      drive(1'b1, 1'b0, b, w);
      drive(1'b0, 1'b0, ~b, 16'($urandom));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, dev_busy, ccw_word);
   endtask

   always @(negedge clk) begin
      if (n_rst === 1'b1) begin
         bit   exp_now;
         exp_t e;
         check("busy_cnt", busy_cnt, exp_cnt(cyc));
         check("ccw_out", ccw_out, m_out);
         check("ccw_overrun", ccw_overrun, ovr_set && (cyc > ovr_cyc));
         exp_now = (q.size() > 0) && (q[0].cyc == cyc);
         check("reply_req", reply_req, exp_now);
         if (exp_now) begin
            e = q.pop_front();
            check("reply_busy", reply_busy, e.busy);
            check("ccw_accepted", ccw_accepted, !e.busy);
            if (e.busy) begin
               if (m_cnt == 0 || (cyc - m_last) >= WIN + 1) m_cnt = 1;
               else if (m_cnt < 3) m_cnt++;
               m_last = cyc;
            end else begin
               m_cnt = 0;
               m_out = e.word;
            end
         end else begin
            check("idle_reply_flags", {reply_busy, ccw_accepted}, 2'b00);
         end
      end
   end

   initial begin
      n_rst = 1'b0; ccw_valid = 1'b0; ccw_err = 1'b0; dev_busy = 1'b0; ccw_word = '0;
      #1;
      check("rst_outputs", {reply_req, reply_busy, ccw_accepted, ccw_overrun, busy_cnt, ccw_out}, 0);
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;

      // Single ready CCW, then busy/busy/busy/ready.
      send(16'hA5C3, 1'b0); idle(10);
      for (int i = 0; i < 3; i++) begin send(16'h1000 + 16'(i), 1'b1); idle(8); end
      send(16'h2222, 1'b0); idle(10);

      // Saturation with five busy CCWs.
      for (int i = 0; i < 5; i++) begin send(16'h3000 + 16'(i), 1'b1); idle(8); end
      send(16'h3333, 1'b0); idle(10);

      // Window expiry, then a fresh busy CCW.
      send(16'h4444, 1'b1); idle(25);
      send(16'h4445, 1'b1); idle(30);

      // Busy reply landing exactly on window expiry.
      send(16'h5555, 1'b1); idle(19);
      send(16'h5556, 1'b1); idle(30);

      // Error word is ignored; CCW inside the gap is dropped and flags overrun.
      drive(1'b1, 1'b1, 1'b0, 16'hDEAD); drive(1'b0, 1'b0, 1'b0, 16'h0); idle(10);
      drive(1'b1, 1'b0, 1'b0, 16'h6666); idle(2);
      drive(1'b1, 1'b0, 1'b0, 16'h7777); idle(10);

      // Reset during GAP aborts the pending reply.
      send(16'h8888, 1'b1);
      @(posedge clk); #3;
      n_rst = 1'b0; #1;
      check("rst_async_outputs", {reply_req, reply_busy, ccw_accepted, ccw_overrun, busy_cnt, ccw_out}, 0);
      q.delete(); pend_end = -1; ovr_set = 0; m_cnt = 0; m_out = '0;
      @(posedge clk); #1 n_rst = 1'b1;
      idle(12);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         drive($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 1'($urandom), 16'($urandom));
      idle(12);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
